debug_probe_mux: RTL and testbench

- Parametrised successor to the top-level hex debug selector and manual CPU clock switch.
- Captures N debug probe words on their own write strobes and shows one channel on DIGITS hex digits.
- Selection is filtered for stability, and the display can be frozen.
- Produces a debounced single-step CPU clock enable in place of a muxed clock.
- Sits between the NES architecture debug outputs/switches and the HexDriver instances.

---
 rtl/dbg_pkg.sv | 19 +
 rtl/debug_probe_mux_if.sv | 15 +
 rtl/dbg_step_gen.sv | 62 ++++++
 rtl/debug_probe_mux.sv | 141 ++++++++++++++
 tb/tb_debug_probe_mux.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dbg_pkg.sv
// Shared types and helpers for the debug probe selector and its single-step generator.
package dbg_pkg;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PULSE, WAIT_RELEASE} step_state_t;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned MAX_BUS_W  = 2048;
  localparam int unsigned MAX_WORD_W = 128;

  // Returns word k of a flattened bus; callers keep only the low word_w bits.
  function automatic logic [MAX_WORD_W-1:0] get_word(input logic [MAX_BUS_W-1:0] bus,
                                                     input int unsigned k,
                                                     input int unsigned word_w);
    logic [MAX_BUS_W-1:0] shifted;
    shifted = bus >> (k * word_w);
    return shifted[MAX_WORD_W-1:0];
  endfunction

endpackage

// File: rtl/debug_probe_mux_if.sv
// Probe capture bus: flattened probe words plus one capture strobe per channel.
interface debug_probe_mux_if
  import dbg_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned DIGITS = 6
);

  logic [NUM_CH*DIGITS*DIGIT_W-1:0] probe_data;
  logic [NUM_CH-1:0]                probe_valid;

  modport master (output probe_data, output probe_valid);
  modport slave  (input  probe_data, input  probe_valid);

endinterface

// File: rtl/dbg_step_gen.sv
// Debounced single-step clock-enable generator: one cpu_ce pulse per accepted press,
// or a constant enable in free-run mode.
module dbg_step_gen
  import dbg_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 250000
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic step_btn_i,
  input  logic run_mode_i,
  output logic cpu_ce_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYC + 1);

  step_state_t     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ce_q, ce_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (step_btn_i) begin
          state_d = DEBOUNCE;
          cnt_d   = '0;
        end
      end
      DEBOUNCE: begin
        if (!step_btn_i) begin
          state_d = IDLE;
        end else if (cnt_q == CntW'(DEBOUNCE_CYC - 1)) begin
          state_d = PULSE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PULSE:        state_d = WAIT_RELEASE;
      WAIT_RELEASE: if (!step_btn_i) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
    // The FSM keeps running in free-run mode; only its pulse is masked.
    ce_d = run_mode_i | (state_q == PULSE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ce_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ce_q    <= ce_d;
    end
  end

  assign cpu_ce_o = ce_q;

endmodule

// File: rtl/debug_probe_mux.sv
// Captures NUM_CH debug probe words and shows a stability-filtered channel on hex digits.
// Define DBG_PROBE_STICKY_EN to build the sticky per-channel change flags.
module debug_probe_mux
  import dbg_pkg::*;
#(
  parameter int unsigned NUM_CH         = 8,
  parameter int unsigned DIGITS         = 6,
  parameter int unsigned SEL_W          = $clog2(NUM_CH),
  parameter int unsigned SEL_STABLE_CYC = 1024,  // must be >= 2
  parameter int unsigned DEBOUNCE_CYC   = 250000
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  debug_probe_mux_if.slave          probe,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      freeze,
  input  logic                      step_btn,
  input  logic                      run_mode,
  output logic                      cpu_ce,
  output logic [DIGITS*DIGIT_W-1:0] hex_digits,
  output logic [SEL_W-1:0]          disp_ch,
  output logic                      stale,
  output logic [NUM_CH-1:0]         change_flags
);

  localparam int unsigned WordW = DIGITS * DIGIT_W;
  localparam int unsigned CntW  = $clog2(SEL_STABLE_CYC);

  logic [WordW-1:0] cap_q [NUM_CH];
  logic [WordW-1:0] word_in [NUM_CH];
  logic [WordW-1:0] hex_q, hex_d, cur_word;
  logic [SEL_W-1:0] disp_q, disp_d, sel_prev_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             stale_q, stale_d;
  logic             cur_valid, new_valid, adopt;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_word
    assign word_in[k] = WordW'(get_word(MAX_BUS_W'(probe.probe_data), k, WordW));
  end

  always_comb begin
    cur_word  = '0;
    cur_valid = 1'b0;
    new_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (disp_q == SEL_W'(k)) begin
        cur_word  = cap_q[k];
        cur_valid = probe.probe_valid[k];
      end
      if (sel == SEL_W'(k)) new_valid = probe.probe_valid[k];
    end
  end

  // The change edge leaves the counter at 0, so adoption lands SEL_STABLE_CYC edges later.
  always_comb begin
    adopt  = 1'b0;
    cnt_d  = cnt_q;
    disp_d = disp_q;
    if (freeze || sel != sel_prev_q || sel == disp_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(SEL_STABLE_CYC - 2)) begin
      cnt_d = '0;
      adopt = (32'(sel) < NUM_CH);
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    if (adopt) disp_d = sel;
    stale_d = adopt ? !new_valid : (cur_valid ? 1'b0 : stale_q);
    hex_d   = freeze ? hex_q : cur_word;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned k = 0; k < NUM_CH; k++) cap_q[k] <= '0;
      hex_q      <= '0;
      disp_q     <= '0;
      sel_prev_q <= '0;
      cnt_q      <= '0;
      stale_q    <= 1'b1;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (probe.probe_valid[k]) cap_q[k] <= word_in[k];
      end
      hex_q      <= hex_d;
      disp_q     <= disp_d;
      sel_prev_q <= sel;
      cnt_q      <= cnt_d;
      stale_q    <= stale_d;
    end
  end

`ifdef DBG_PROBE_STICKY_EN
  logic [NUM_CH-1:0] flags_q, flags_d;
  logic              clr_pend_q, clr_pend_d;

  // Set is applied last so it wins over a coincident clear.
  always_comb begin
    flags_d    = flags_q;
    clr_pend_d = clr_pend_q;
    if (clr_pend_q && !freeze) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (disp_q == SEL_W'(k)) flags_d[k] = 1'b0;
      end
      clr_pend_d = 1'b0;
    end
    if (adopt) clr_pend_d = 1'b1;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (probe.probe_valid[k] && word_in[k] != cap_q[k]) flags_d[k] = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      flags_q    <= '0;
      clr_pend_q <= 1'b0;
    end else begin
      flags_q    <= flags_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  assign change_flags = flags_q;
`else
  assign change_flags = '0;
`endif

  dbg_step_gen #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_step_gen (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .step_btn_i(step_btn),
    .run_mode_i(run_mode),
    .cpu_ce_o  (cpu_ce)
  );

  assign hex_digits = hex_q;
  assign disp_ch    = disp_q;
  assign stale      = stale_q;

endmodule

// File: tb/tb_debug_probe_mux.sv
// Bench for debug_probe_mux: directed cases plus random traffic against a behavioural model.
module tb_debug_probe_mux;

  localparam int unsigned NCh       = 8;
  localparam int unsigned Dig       = 6;
  localparam int unsigned SelW      = 4;
  localparam int unsigned SelStable = 4;
  localparam int unsigned Deb       = 8;
  localparam int unsigned WordW     = 4 * Dig;
`ifdef DBG_PROBE_STICKY_EN
  localparam bit Sticky = 1'b1;
`else
  localparam bit Sticky = 1'b0;
`endif

  logic             Clk      = 1'b0;
  logic             Reset_n  = 1'b0;
  logic [SelW-1:0]  sel      = '0;
  logic             freeze   = 1'b0;
  logic             step_btn = 1'b0;
  logic             run_mode = 1'b0;
  logic             cpu_ce;
  logic [WordW-1:0] hex_digits;
  logic [SelW-1:0]  disp_ch;
  logic             stale;
  logic [NCh-1:0]   change_flags;

  debug_probe_mux_if #(.NUM_CH(NCh), .DIGITS(Dig)) probe_if ();

  debug_probe_mux #(
    .NUM_CH        (NCh),
    .DIGITS        (Dig),
    .SEL_W         (SelW),
    .SEL_STABLE_CYC(SelStable),
    .DEBOUNCE_CYC  (Deb)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .probe       (probe_if),
    .sel         (sel),
    .freeze      (freeze),
    .step_btn    (step_btn),
    .run_mode    (run_mode),
    .cpu_ce      (cpu_ce),
    .hex_digits  (hex_digits),
    .disp_ch     (disp_ch),
    .stale       (stale),
    .change_flags(change_flags)
  );

  always #5 Clk = ~Clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model, stepped on every active edge from the sampled inputs.
  logic [WordW-1:0] m_cap [NCh];
  logic [WordW-1:0] m_w [NCh];
  logic [WordW-1:0] m_hex;
  int               m_disp, m_prev_sel, m_run, m_hi, m_s;
  bit               m_stale, m_pend, m_pulse, m_ce, m_adopt;
  bit [NCh-1:0]     m_flags;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < NCh; k++) m_cap[k] = '0;
      m_hex = '0; m_disp = 0; m_prev_sel = 0; m_run = 0; m_hi = 0;
      m_stale = 1'b1; m_pend = 1'b0; m_pulse = 1'b0; m_ce = 1'b0; m_flags = '0;
    end else begin
      m_s = int'(sel);
      for (int k = 0; k < NCh; k++) m_w[k] = probe_if.probe_data[k*WordW +: WordW];
      if (!freeze) m_hex = m_cap[m_disp];
`ifdef DBG_PROBE_STICKY_EN
      if (m_pend && !freeze) begin
        m_flags[m_disp] = 1'b0;
        m_pend = 1'b0;
      end
      for (int k = 0; k < NCh; k++)
        if (probe_if.probe_valid[k] && m_w[k] != m_cap[k]) m_flags[k] = 1'b1;
`endif
      for (int k = 0; k < NCh; k++) if (probe_if.probe_valid[k]) m_cap[k] = m_w[k];
      // Length of the current run of unfrozen edges holding one sel that differs from disp.
      m_run   = (!freeze && m_s == m_prev_sel && m_s != m_disp) ? m_run + 1 : 0;
      m_adopt = (m_run == SelStable - 1) && (m_s < NCh);
      if (m_adopt) begin
        m_stale = !probe_if.probe_valid[m_s];
        m_disp  = m_s;
        m_run   = 0;
        m_pend  = 1'b1;
      end else if (probe_if.probe_valid[m_disp]) begin
        m_stale = 1'b0;
      end
      m_prev_sel = m_s;
      m_ce    = run_mode || m_pulse;
      m_hi    = step_btn ? m_hi + 1 : 0;
      m_pulse = (m_hi == Deb + 1);
    end
  end

  bit chk_en = 1'b0;
  always @(negedge Clk) begin
    if (chk_en && Reset_n) begin
      check_eq("hex",   64'(hex_digits),   64'(m_hex));
      check_eq("disp",  64'(disp_ch),      64'(m_disp));
      check_eq("stale", 64'(stale),        64'(m_stale));
      check_eq("ce",    64'(cpu_ce),       64'(m_ce));
      check_eq("flags", 64'(change_flags), 64'(m_flags));
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
    probe_if.probe_valid = '0;
  endtask

  task automatic capture(input int k, input logic [WordW-1:0] v);
    probe_if.probe_data[k*WordW +: WordW] = v;
    probe_if.probe_valid[k] = 1'b1;
    cyc();
  endtask

  task automatic press(input int hold, input int window, output int pulses, output int first);
    pulses   = 0;
    first    = -1;
    step_btn = 1'b1;
    for (int i = 1; i <= window; i++) begin
      cyc();
      if (i == hold) step_btn = 1'b0;
      if (cpu_ce) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
  endtask

  initial begin
    int pulses, first, cnt, hi_left, lo_left;
    probe_if.probe_data  = '0;
    probe_if.probe_valid = '0;
    repeat (3) @(posedge Clk);
    #1;
    check_eq("rst_hex",   64'(hex_digits),   64'h0);
    check_eq("rst_disp",  64'(disp_ch),      64'h0);
    check_eq("rst_stale", 64'(stale),        64'h1);
    check_eq("rst_ce",    64'(cpu_ce),       64'h0);
    check_eq("rst_flags", 64'(change_flags), 64'h0);
    Reset_n = 1'b1;
    chk_en  = 1'b1;

    // Capture and display on channel 2.
    sel = 4'd2;
    repeat (4) cyc();
    check_eq("adopt2", 64'(disp_ch), 64'd2);
    check_eq("adopt2_stale", 64'(stale), 64'h1);
    capture(2, 24'h00C0DE);
    check_eq("cap_stale", 64'(stale), 64'h0);
    cyc();
    check_eq("cap_hex", 64'(hex_digits), 64'h00C0DE);
    capture(5, 24'hABCDEF);
    cyc();
    check_eq("other_ch_hex", 64'(hex_digits), 64'h00C0DE);

    // Select filter.
    for (int i = 0; i < 6; i++) begin
      sel = (i % 2 != 0) ? 4'd4 : 4'd3;
      cyc();
      cyc();
    end
    check_eq("sel_toggle", 64'(disp_ch), 64'd2);
    sel = 4'd9;
    repeat (12) cyc();
    check_eq("sel_oob", 64'(disp_ch), 64'd2);
    sel = 4'd3;
    repeat (3) cyc();
    check_eq("sel_early", 64'(disp_ch), 64'd2);
    cyc();
    check_eq("sel_adopt3", 64'(disp_ch), 64'd3);
    check_eq("sel_adopt3_stale", 64'(stale), 64'h1);

    // Freeze.
    capture(3, 24'h111111);
    cyc();
    check_eq("pre_frz_hex", 64'(hex_digits), 64'h111111);
    freeze = 1'b1;
    capture(3, 24'h123456);
    repeat (2) cyc();
    check_eq("frz_hold", 64'(hex_digits), 64'h111111);
    sel = 4'd1;
    repeat (8) cyc();
    check_eq("frz_sel", 64'(disp_ch), 64'd3);
    sel    = 4'd3;
    freeze = 1'b0;
    cyc();
    check_eq("frz_release", 64'(hex_digits), 64'h123456);

    // Single step.
    run_mode = 1'b0;
    press(5, 15, pulses, first);
    check_eq("bounce_pulses", 64'(pulses), 64'd0);
    press(20, 30, pulses, first);
    check_eq("press_pulses", 64'(pulses), 64'd1);
    check_eq("press_latency", 64'(first), 64'd10);
    run_mode = 1'b1;
    cyc();
    press(20, 30, pulses, first);
    check_eq("run_ce", 64'(pulses), 64'd30);
    step_btn = 1'b1;
    repeat (12) cyc();
    run_mode = 1'b0;
    cyc();
    cnt = 0;
    repeat (10) begin
      cyc();
      if (cpu_ce) cnt++;
    end
    check_eq("held_mask", 64'(cnt), 64'd0);
    step_btn = 1'b0;
    repeat (3) cyc();

    // Asynchronous reset while the FSM sits in PULSE.
    step_btn = 1'b1;
    repeat (9) cyc();
    #2;
    chk_en  = 1'b0;
    Reset_n = 1'b0;
    #1;
    check_eq("rst2_ce",    64'(cpu_ce),     64'h0);
    check_eq("rst2_hex",   64'(hex_digits), 64'h0);
    check_eq("rst2_stale", 64'(stale),      64'h1);
    check_eq("rst2_disp",  64'(disp_ch),    64'h0);
    cyc();
    check_eq("rst2_ce_hold", 64'(cpu_ce), 64'h0);
    step_btn = 1'b0;
    Reset_n  = 1'b1;
    chk_en   = 1'b1;

    // Sticky change flags.
    capture(4, 24'h000000);
    check_eq("stk_same", 64'(change_flags[4]), 64'h0);
    capture(4, 24'h0000AA);
    check_eq("stk_set", 64'(change_flags[4]), 64'(Sticky));
    sel = 4'd4;
    repeat (5) cyc();
    check_eq("stk_clr", 64'(change_flags[4]), 64'h0);
    sel = 4'd6;
    repeat (5) cyc();
    sel = 4'd4;
    repeat (4) cyc();
    capture(4, 24'h0000CC);
    check_eq("stk_coincide", 64'(change_flags[4]), 64'(Sticky));

    // Random traffic checked every cycle by the model.
    hi_left = 0;
    lo_left = 3;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NCh; k++) begin
        if ($urandom_range(3) == 0) begin
          probe_if.probe_valid[k] = 1'b1;
          if ($urandom_range(3) != 0)
            probe_if.probe_data[k*WordW +: WordW] = WordW'($urandom);
        end
      end
      if ($urandom_range(5) == 0)  sel      = SelW'($urandom_range(11));
      if ($urandom_range(39) == 0) freeze   = ~freeze;
      if ($urandom_range(99) == 0) run_mode = ~run_mode;
      if (step_btn) begin
        hi_left--;
        if (hi_left <= 0) begin
          step_btn = 1'b0;
          lo_left  = int'($urandom_range(6, 2));
        end
      end else begin
        lo_left--;
        if (lo_left <= 0) begin
          step_btn = 1'b1;
          hi_left  = int'($urandom_range(20, 1));
        end
      end
      cyc();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
